// File: rtl/ball_ctrl.sv
// rtl/ball_ctrl.sv - Pong ball motion, paddle collision and scoring FSM.
// Optional PONG_SPEEDUP_EN: each paddle hit raises ball speed up to MAX_SPEED.
module ball_ctrl #(
    parameter int WIDTH        = 32,
    parameter int HEIGHT       = 32,
    parameter int SCREEN_W     = 1024,
    parameter int SCREEN_H     = 768,
    parameter int PADDLE_W     = 16,
    parameter int PADDLE_H     = 128,
    parameter int SPEED        = 4,
    parameter int MAX_SPEED    = 12,
    parameter int SERVE_FRAMES = 60,
    parameter int WIN_SCORE    = 9
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        frame_tick,
    input  logic        start,
    input  logic [9:0]  paddle_l_y,
    input  logic [9:0]  paddle_r_y,
    output logic [10:0] x,
    output logic [9:0]  y,
    output logic [3:0]  score_l,
    output logic [3:0]  score_r,
    output logic        game_over,
    output logic        playing
);
    localparam logic [11:0] XC      = 12'((SCREEN_W - WIDTH) / 2);
    localparam logic [11:0] YC      = 12'((SCREEN_H - HEIGHT) / 2);
    localparam logic [11:0] BW      = 12'(WIDTH);
    localparam logic [11:0] BH      = 12'(HEIGHT);
    localparam logic [11:0] SW      = 12'(SCREEN_W);
    localparam logic [11:0] SH      = 12'(SCREEN_H);
    localparam logic [11:0] PW      = 12'(PADDLE_W);
    localparam logic [11:0] PH      = 12'(PADDLE_H);
    localparam logic [11:0] SPD0    = 12'(SPEED);
    localparam logic [11:0] SPD_MAX = 12'(MAX_SPEED);
    localparam logic [15:0] SERVE_N = 16'(SERVE_FRAMES);
    localparam logic [3:0]  WIN     = 4'(WIN_SCORE);

    typedef enum logic [1:0] {S_IDLE, S_SERVE, S_PLAY, S_OVER} state_t;

    state_t      r_state;
    logic [10:0] r_x;
    logic [9:0]  r_y;
    logic        r_dx, r_dy;
    logic [3:0]  r_score_l, r_score_r;
    logic        r_game_over, r_playing;
    logic [15:0] r_cnt;

    logic [11:0] w_spd;
    logic [11:0] w_x12, w_y12, w_pl, w_pr;
    logic [11:0] w_nx, w_ny;
    logic        w_ndx, w_ndy;
    logic        w_l_evt, w_r_evt, w_l_hit, w_r_hit, w_l_miss, w_r_miss;
    logic [3:0]  w_sl_inc, w_sr_inc;

    // All geometry is evaluated at 12 bits so sums and differences never wrap.
    assign w_x12    = {1'b0, r_x};
    assign w_y12    = {2'b0, r_y};
    assign w_pl     = {2'b0, paddle_l_y};
    assign w_pr     = {2'b0, paddle_r_y};
    assign w_l_evt  = !r_dx && (w_x12 < PW + w_spd);
    assign w_r_evt  = r_dx && (w_x12 + BW + w_spd > SW - PW);
    assign w_l_hit  = (w_y12 + BH > w_pl) && (w_y12 < w_pl + PH);
    assign w_r_hit  = (w_y12 + BH > w_pr) && (w_y12 < w_pr + PH);
    assign w_l_miss = w_l_evt && !w_l_hit;
    assign w_r_miss = w_r_evt && !w_r_hit;
    assign w_sl_inc = (r_score_l >= WIN) ? WIN : r_score_l + 4'd1;
    assign w_sr_inc = (r_score_r >= WIN) ? WIN : r_score_r + 4'd1;

    always_comb begin
        w_ny  = w_y12;
        w_ndy = r_dy;
        if (!r_dy) begin
            if (w_y12 < w_spd) begin
                w_ny  = '0;
                w_ndy = 1'b1;
            end else begin
                w_ny = w_y12 - w_spd;
            end
        end else if (w_y12 + BH + w_spd > SH) begin
            w_ny  = SH - BH;
            w_ndy = 1'b0;
        end else begin
            w_ny = w_y12 + w_spd;
        end
        w_nx  = r_dx ? (w_x12 + w_spd) : (w_x12 - w_spd);
        w_ndx = r_dx;
        if (w_l_evt) begin
            w_nx  = PW;
            w_ndx = 1'b1;
        end else if (w_r_evt) begin
            w_nx  = SW - PW - BW;
            w_ndx = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_x         <= XC[10:0];
            r_y         <= YC[9:0];
            r_dx        <= 1'b1;
            r_dy        <= 1'b1;
            r_score_l   <= '0;
            r_score_r   <= '0;
            r_game_over <= 1'b0;
            r_playing   <= 1'b0;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_OVER: begin
                    if (start) begin
                        r_state     <= S_SERVE;
                        r_score_l   <= '0;
                        r_score_r   <= '0;
                        r_cnt       <= SERVE_N;
                        r_game_over <= 1'b0;
                    end
                end
                S_SERVE: begin
                    if (frame_tick) begin
                        if (r_cnt <= 16'd1) begin
                            r_cnt     <= '0;
                            r_state   <= S_PLAY;
                            r_playing <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt - 16'd1;
                        end
                    end
                end
                S_PLAY: begin
                    if (frame_tick) begin
                        r_dy <= w_ndy;
                        if (w_l_miss || w_r_miss) begin
                            r_x       <= XC[10:0];
                            r_y       <= YC[9:0];
                            r_cnt     <= SERVE_N;
                            r_playing <= 1'b0;
                            r_dx      <= w_r_miss;
                            r_state   <= S_SERVE;
                            if (w_l_miss) r_score_r <= w_sr_inc;
                            else          r_score_l <= w_sl_inc;
                            if ((w_l_miss && w_sr_inc == WIN) || (w_r_miss && w_sl_inc == WIN)) begin
                                r_state     <= S_OVER;
                                r_game_over <= 1'b1;
                            end
                        end else begin
                            r_x  <= w_nx[10:0];
                            r_y  <= w_ny[9:0];
                            r_dx <= w_ndx;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef PONG_SPEEDUP_EN
    logic [11:0] r_spd;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_spd <= SPD0;
        end else if ((r_state == S_IDLE || r_state == S_OVER) && start) begin
            r_spd <= SPD0;
        end else if (r_state == S_PLAY && frame_tick) begin
            if (w_l_miss || w_r_miss)
                r_spd <= SPD0;
            else if ((w_l_evt || w_r_evt) && r_spd < SPD_MAX)
                r_spd <= r_spd + 12'd1;
        end
    end
    assign w_spd = r_spd;
`else
    assign w_spd = (SPD0 > SPD_MAX) ? SPD_MAX : SPD0;
`endif

    assign x         = r_x;
    assign y         = r_y;
    assign score_l   = r_score_l;
    assign score_r   = r_score_r;
    assign game_over = r_game_over;
    assign playing   = r_playing;
endmodule

// File: tb/tb_ball_ctrl.sv
// tb/tb_ball_ctrl.sv - Self-checking bench for ball_ctrl against an integer game model.
module tb_ball_ctrl;
    localparam int W = 32, H = 32, SW = 1024, SH = 768, PW = 16, PH = 128;
    localparam int SPD = 4, MAXS = 12, SF = 60, WIN = 9;
    localparam int XC = (SW - W) / 2, YC = (SH - H) / 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        frame_tick = 1'b0;
    logic        start = 1'b0;
    logic [9:0]  paddle_l_y = '0;
    logic [9:0]  paddle_r_y = '0;
    logic [10:0] x;
    logic [9:0]  y;
    logic [3:0]  score_l, score_r;
    logic        game_over, playing;

    ball_ctrl u_dut (
        .clk(clk), .reset_n(reset_n), .frame_tick(frame_tick), .start(start),
        .paddle_l_y(paddle_l_y), .paddle_r_y(paddle_r_y),
        .x(x), .y(y), .score_l(score_l), .score_r(score_r),
        .game_over(game_over), .playing(playing)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef enum {M_IDLE, M_SERVE, M_PLAY, M_OVER} mstate_t;
    mstate_t ms;
    int mx, my, mdx, mdy, msl, msr, mcnt, mspd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        ms = M_IDLE; mx = XC; my = YC; mdx = 1; mdy = 1;
        msl = 0; msr = 0; mcnt = 0; mspd = SPD;
    endtask

    task automatic concede(input int to_left);
        if (to_left) msl = (msl + 1 > WIN) ? WIN : msl + 1;
        else         msr = (msr + 1 > WIN) ? WIN : msr + 1;
        mx = XC; my = YC; mdx = to_left; mspd = SPD; mcnt = SF;
        ms = (msl == WIN || msr == WIN) ? M_OVER : M_SERVE;
    endtask

    task automatic bump_speed();
`ifdef PONG_SPEEDUP_EN
        if (mspd < MAXS) mspd++;
`endif
    endtask

    task automatic play_frame(input int pl, input int pr);
        int ny, nx;
        bit scored;
        scored = 0;
        if (mdy == 0) begin
            if (my < mspd) begin ny = 0; mdy = 1; end
            else ny = my - mspd;
        end else begin
            if (my + H + mspd > SH) begin ny = SH - H; mdy = 0; end
            else ny = my + mspd;
        end
        nx = (mdx == 1) ? mx + mspd : mx - mspd;
        if (mdx == 0 && mx < PW + mspd) begin
            if (my + H > pl && my < pl + PH) begin nx = PW; mdx = 1; bump_speed(); end
            else begin concede(0); scored = 1; end
        end else if (mdx == 1 && mx + W + mspd > SW - PW) begin
            if (my + H > pr && my < pr + PH) begin nx = SW - PW - W; mdx = 0; bump_speed(); end
            else begin concede(1); scored = 1; end
        end
        if (!scored) begin mx = nx; my = ny; end
    endtask

    task automatic model_step(input bit st, input bit tk);
        case (ms)
            M_IDLE, M_OVER: if (st) begin
                ms = M_SERVE; msl = 0; msr = 0; mcnt = SF; mspd = SPD;
            end
            M_SERVE: if (tk) begin
                mcnt--;
                if (mcnt == 0) ms = M_PLAY;
            end
            M_PLAY: if (tk) play_frame(int'(paddle_l_y), int'(paddle_r_y));
            default: ;
        endcase
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_x"}, 32'(x), mx);
        chk({tag, "_y"}, 32'(y), my);
        chk({tag, "_score_l"}, 32'(score_l), msl);
        chk({tag, "_score_r"}, 32'(score_r), msr);
        chk({tag, "_game_over"}, 32'(game_over), (ms == M_OVER) ? 1 : 0);
        chk({tag, "_playing"}, 32'(playing), (ms == M_PLAY) ? 1 : 0);
    endtask

    task automatic step(input bit st, input bit tk);
        start = st;
        frame_tick = tk;
        @(posedge clk);
        model_step(st, tk);
        #1;
        start = 1'b0;
        frame_tick = 1'b0;
        check_all("cyc");
    endtask

    function automatic int paddle_for(input int by);
        int mode, p;
        mode = $urandom_range(0, 9);
        case (mode)
            6:       p = by + H - 1;
            7:       p = by + H;
            8:       p = by - PH + 1;
            9:       p = (by >= 400) ? 0 : 640;
            default: p = by - $urandom_range(0, 95);
        endcase
        if (p < 0) p = 0;
        if (p > 1023) p = 1023;
        return p;
    endfunction

    initial begin
        model_reset();
        #12;
        check_all("reset");
        @(posedge clk);
        #1 reset_n = 1'b1;

        step(0, 1);
        chk("idle_tick_playing", 32'(playing), 0);
        step(1, 1);
        chk("start_wins_playing", 32'(playing), 0);
        repeat (59) step(0, 1);
        chk("serve59_playing", 32'(playing), 0);
        step(0, 1);
        chk("serve60_playing", 32'(playing), 1);
        chk("serve60_x", 32'(x), 496);
        chk("serve60_y", 32'(y), 368);
        step(0, 0);
        chk("no_tick_x", 32'(x), 496);
        step(0, 1);
        chk("first_move_x", 32'(x), 500);
        chk("first_move_y", 32'(y), 372);

        for (int n = 0; n < 40000 && ms != M_OVER; n++) begin
            paddle_l_y = 10'(paddle_for(my));
            paddle_r_y = 10'(paddle_for(my));
            step($urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0);
        end
        chk("game_over_reached", 32'(game_over), 1);
        chk("win_score", 32'((score_l > score_r) ? score_l : score_r), WIN);

        step(0, 1);
        chk("over_tick_ignored", 32'(game_over), 1);
        step(1, 0);
        chk("restart_score_l", 32'(score_l), 0);
        chk("restart_score_r", 32'(score_r), 0);
        chk("restart_game_over", 32'(game_over), 0);
        repeat (SF) step(0, 1);
        chk("replay_playing", 32'(playing), 1);
        repeat (5) step(0, 1);

        #3 reset_n = 1'b0;
        #1;
        model_reset();
        check_all("async_reset");
        @(posedge clk);
        #1 reset_n = 1'b1;
        step(0, 1);
        chk("post_reset_tick_playing", 32'(playing), 0);
        chk("post_reset_tick_x", 32'(x), 496);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
